// File: rtl/module_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : module_timer_ctrl
// Brief    : Memory-mapped timer controller. A register file (CTRL, PRESC,
//            TOP, VAL) drives a prescaler and a main counter with one-shot or
//            periodic wrap, a sticky overflow flag and a level interrupt.
//            Optional macro TIMER_CTRL_EXT_TICK_EN adds an external tick
//            source (port ext_tick, CTRL[4] src_ext).
// Revision : 1.0 - initial release
// ============================================================================
module module_timer_ctrl #(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
`ifdef TIMER_CTRL_EXT_TICK_EN
    input  logic        ext_tick,
`endif
    output logic [31:0] rdata,
    output logic        irq,
    output logic        ovf_pulse
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_PRESC = 2'd1;
    localparam logic [1:0] ADDR_TOP   = 2'd2;
    localparam logic [1:0] ADDR_VAL   = 2'd3;

    logic [1:0]             state;
    logic                   ctrl_enable;
    logic                   ctrl_periodic;
    logic                   ctrl_irq_en;
    logic                   ctrl_flag;
    logic                   src_ext;
    logic                   ext_rise;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [WIDTH-1:0]       top_reg;
    logic [WIDTH-1:0]       val;

    logic                   ctrl_wr;
    logic                   count_en;
    logic                   unused_wdata;

    assign ctrl_wr  = we && (addr == ADDR_CTRL);
    // Prescaler advances every clk unless the external source is selected
    assign count_en = ~src_ext | ext_rise;
    assign irq      = ctrl_flag & ctrl_irq_en;
    // Upper bus bits beyond the register widths carry no state
    assign unused_wdata = ^wdata;

`ifdef TIMER_CTRL_EXT_TICK_EN
    logic [1:0] ext_sync;
    logic       ext_prev;

    // Two-flop synchroniser followed by a registered rising-edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_sync <= 2'b00;
            ext_prev <= 1'b0;
            ext_rise <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[0], ext_tick};
            ext_prev <= ext_sync[1];
            ext_rise <= ext_sync[1] & ~ext_prev;
        end
    end

    // Clock-source select bit of CTRL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ext <= 1'b0;
        end else if (ctrl_wr) begin
            src_ext <= wdata[4];
        end
    end
`else
    assign src_ext  = 1'b0;
    assign ext_rise = 1'b0;
`endif

    // Register file, state machine, prescaler and main counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ctrl_enable   <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_flag     <= 1'b0;
            presc_reg     <= '0;
            top_reg       <= '0;
            presc_cnt     <= '0;
            val           <= '0;
            ovf_pulse     <= 1'b0;
        end else begin
            ovf_pulse <= 1'b0;

            if (ctrl_wr) begin
                ctrl_enable   <= wdata[0];
                ctrl_periodic <= wdata[1];
                ctrl_irq_en   <= wdata[2];
                if (wdata[3]) begin
                    ctrl_flag <= 1'b0;
                end
            end
            if (we && (addr == ADDR_PRESC)) begin
                presc_reg <= wdata[PRESC_WIDTH-1:0];
            end
            if (we && (addr == ADDR_TOP)) begin
                top_reg <= wdata[WIDTH-1:0];
            end

            // Counting uses the pre-write PRESC/TOP/periodic values; the
            // overflow assignments come last so they win over a same-cycle
            // flag clear or enable write.
            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && wdata[0]) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (ctrl_wr && wdata[0]) begin
                        state     <= ST_RUN;
                        presc_cnt <= '0;
                        val       <= '0;
                    end
                end
                ST_RUN: begin
                    if (ctrl_wr && !wdata[0]) begin
                        state <= ST_IDLE;
                    end else if (count_en) begin
                        if (presc_cnt == presc_reg) begin
                            presc_cnt <= '0;
                            if (val >= top_reg) begin
                                val       <= '0;
                                ctrl_flag <= 1'b1;
                                ovf_pulse <= 1'b1;
                                if (!ctrl_periodic) begin
                                    ctrl_enable <= 1'b0;
                                    state       <= ST_DONE;
                                end
                            end else begin
                                val <= val + WIDTH'(1);
                            end
                        end else begin
                            presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational, zero-extended register readback
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:  rdata[4:0] = {src_ext, ctrl_flag, ctrl_irq_en,
                                      ctrl_periodic, ctrl_enable};
            ADDR_PRESC: rdata[PRESC_WIDTH-1:0] = presc_reg;
            ADDR_TOP:   rdata[WIDTH-1:0] = top_reg;
            ADDR_VAL:   rdata[WIDTH-1:0] = val;
            default:    rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/module_timer_ctrl.md
Name: module_timer_ctrl

Overview:
Memory-mapped timer controller that sequences a prescaler counter and a main counter from one register file. Provides start/stop, one-shot and periodic modes, compare-based wrap, a sticky overflow flag and an interrupt line. Sits on the peripheral bus next to the core. It is the software-facing front end that configures and drives the enable/max/top counter datapath.

Parameters:
WIDTH, 16, width of the main counter and TOP register (bits [WIDTH-1:0] of bus data)
PRESC_WIDTH, 8, width of the prescaler counter and PRESC register

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
we  in  1  bus write strobe, sampled on rising clk
addr  in  2  register select: 0 CTRL, 1 PRESC, 2 TOP, 3 VAL
wdata  in  32  bus write data
rdata  out  32  combinational read of register at addr, zero-extended
irq  out  1  level interrupt = CTRL.flag & CTRL.irq_en
ovf_pulse  out  1  one-cycle pulse on every main-counter wrap

Behaviour:
- CTRL bits: [0] enable, [1] periodic (0 = one-shot), [2] irq_en, [3] flag (sticky; write 1 clears, write 0 no effect), others read 0.
- PRESC and TOP are R/W. VAL is read-only current main count; writes to VAL are ignored.
- Reset: CTRL = 0, PRESC = 0, TOP = 0, VAL = 0, prescaler count = 0, state IDLE, irq = 0, ovf_pulse = 0, rdata = 0.
- States: IDLE (stopped, counts held), RUN, DONE (one-shot finished).
- IDLE -> RUN when a CTRL write sets enable; counting resumes from the held values.
- RUN -> IDLE when a CTRL write clears enable; prescaler count and VAL freeze.
- DONE -> RUN when a CTRL write sets enable; prescaler count and VAL restart from 0.
- RUN, each clk:
  - If presc_cnt == PRESC, then presc_cnt <= 0 and tick = 1; otherwise presc_cnt += 1.
  - PRESC = 0 gives a tick every cycle.
- On tick:
  - If VAL >= TOP: VAL <= 0, flag <= 1, ovf_pulse = 1 in the following cycle.
  - Also, if one-shot, enable <= 0 and state -> DONE.
  - Otherwise VAL += 1.
  - The >= comparison means a TOP written below the current VAL wraps on the next tick. TOP = 0 wraps on every tick.
- Latency: the register write takes effect on the clock edge it is sampled. The first tick after IDLE -> RUN comes PRESC+1 cycles later.
- Simultaneous events:
  - Flag set by overflow wins over a same-cycle W1C; flag stays 1.
  - A CTRL write clearing enable in the same cycle as a tick: the tick is discarded and counts are held.
  - A PRESC/TOP write in the same cycle as a tick: the tick uses the old value.
- irq is a pure function of registered bits and is glitch-free; it stays high until flag is cleared or irq_en is cleared.
- Reset asserted mid-run: all outputs drop to reset values asynchronously; no pulse is emitted.

Optional Feature:
Macro TIMER_CTRL_EXT_TICK_EN.
- Defined:
  - Adds input port ext_tick (1 bit).
  - CTRL[4] = src_ext (R/W). When set, the prescaler advances only on a rising edge of ext_tick, detected after a 2-flop synchronizer plus an edge-detect flop (3 cycles of input latency). When clear, the prescaler advances every clk.
  - src_ext resets to 0.
- Undefined: no ext_tick port; CTRL[4] reads 0 and writes to it are ignored.

Test Plan:
- Reset with all registers written non-zero, then assert reset -> every read returns 0; irq = 0; ovf_pulse = 0; no counting after release.
- PRESC = 0, TOP = 3, CTRL = 0x7 -> VAL reads 0,1,2,3,0,1 on successive cycles; ovf_pulse high exactly 1 cycle after each wrap; irq rises at first wrap and holds until CTRL write 0x7|0x8, then falls.
- PRESC = 2, TOP = 1, CTRL = 0x1 (one-shot) -> VAL = 1 after 3 cycles, wrap after 6; CTRL reads 0x8; VAL held at 0 for 20 further cycles; writing CTRL = 0x1 restarts from 0.
- Periodic run, PRESC = 0, TOP = 100; write CTRL enable = 0 when VAL = 5 -> VAL stays 5 for 10 cycles; re-enable -> next read 6.
- Running with VAL = 10, write TOP = 4 -> next tick wraps: VAL = 0, flag = 1, one ovf_pulse.
- Arrange a tick that wraps in the same cycle as a W1C write of flag -> flag reads 1 afterward. Separately, a disable write coincident with a tick -> VAL unchanged.
